// File: rtl/vga_game_pkg.sv
// Shared types, widths and movement helpers for the VGA sprite game logic.
package vga_game_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned RGB_W     = 4;
  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic [COORD_W:0]          ucoord_t;
  typedef logic signed [COORD_W:0]   scoord_t;

  typedef logic [1:0] pos_state_t;
  localparam pos_state_t StIdle   = 2'd0;
  localparam pos_state_t StCalc   = 2'd1;
  localparam pos_state_t StCommit = 2'd2;

  // One axis of motion: a lone pressed switch wins, both/neither hold still unless
  // autonomous motion is enabled; the result is always clamped to [lo, hi].
  function automatic coord_t axis_pos(input scoord_t pos, input logic dir, input logic neg_p,
                                      input logic pos_p, input logic auto_en,
                                      input scoord_t step, input scoord_t lo,
                                      input scoord_t hi);
    scoord_t t;
    t = pos;
    if (neg_p && !pos_p) t = pos - step;
    else if (pos_p && !neg_p) t = pos + step;
    else if (auto_en && !neg_p && !pos_p) t = dir ? pos + step : pos - step;
    if (t < lo) t = lo;
    else if (t > hi) t = hi;
    return coord_t'(t);
  endfunction

  // Direction after a move: follows a lone pressed switch, flips when an autonomous
  // move would cross a limit, otherwise unchanged.
  function automatic logic axis_dir(input scoord_t pos, input logic dir, input logic neg_p,
                                    input logic pos_p, input scoord_t step,
                                    input scoord_t lo, input scoord_t hi);
    scoord_t t;
    logic    d;
    d = dir;
    if (neg_p && !pos_p) d = 1'b0;
    else if (pos_p && !neg_p) d = 1'b1;
    else if (!neg_p && !pos_p) begin
      t = dir ? pos + step : pos - step;
      if (t > hi) d = 1'b0;
      else if (t < lo) d = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus saturating-count debouncer for one active-low switch.
module switch_debounce #(
  parameter int unsigned DEB_BITS = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_ni,
  output logic pressed_o
);

  logic [1:0]          sync_q, sync_d;
  logic                stable_q, stable_d;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d   = {sync_q[0], sw_ni};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pressed_o = ~stable_q;

endmodule

// File: rtl/vga_sprite_ctrl.sv
// Single-sprite VGA game logic: debounced switches move a clamped sprite during vblank.
// Define VGA_SPRITE_BOUNCE_EN to make the sprite bounce autonomously when no switch is held.
module vga_sprite_ctrl
  import vga_game_pkg::*;
#(
  parameter int unsigned H_RES     = H_RES_DEF,
  parameter int unsigned V_RES     = V_RES_DEF,
  parameter int unsigned BORDER    = 10,
  parameter int unsigned SPR_W     = 30,
  parameter int unsigned SPR_H     = 30,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned DEB_BITS  = 16,
  parameter int unsigned START_X   = 320,
  parameter int unsigned START_Y   = 240,
  parameter logic [3*RGB_W-1:0] SPR_RGB = 12'h070,
  parameter logic [3*RGB_W-1:0] BRD_RGB = 12'h773
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               up_n,
  input  logic               dn_n,
  input  logic               left_n,
  input  logic               right_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               blank,
  output logic [RGB_W-1:0]   RED,
  output logic [RGB_W-1:0]   GREEN,
  output logic [RGB_W-1:0]   BLUE,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               frame_tick
);

  localparam int unsigned FcntW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [FcntW-1:0] FcntLast = FcntW'(FRAME_DIV - 1);

  localparam scoord_t StepS = scoord_t'(STEP);
  localparam scoord_t XMin  = scoord_t'(BORDER);
  localparam scoord_t XMax  = scoord_t'(H_RES - BORDER - SPR_W);
  localparam scoord_t YMin  = scoord_t'(BORDER);
  localparam scoord_t YMax  = scoord_t'(V_RES - BORDER - SPR_H);

  localparam ucoord_t SprWU = ucoord_t'(SPR_W);
  localparam ucoord_t SprHU = ucoord_t'(SPR_H);
  localparam ucoord_t BrdU  = ucoord_t'(BORDER);
  localparam ucoord_t BrdRU = ucoord_t'(H_RES - BORDER);
  localparam ucoord_t BrdBU = ucoord_t'(V_RES - BORDER);

  logic up_p, dn_p, lf_p, rt_p;

  switch_debounce #(.DEB_BITS(DEB_BITS)) u_deb_up (
    .clk_i(CLK), .rst_i(RST), .sw_ni(up_n), .pressed_o(up_p)
  );
  switch_debounce #(.DEB_BITS(DEB_BITS)) u_deb_dn (
    .clk_i(CLK), .rst_i(RST), .sw_ni(dn_n), .pressed_o(dn_p)
  );
  switch_debounce #(.DEB_BITS(DEB_BITS)) u_deb_left (
    .clk_i(CLK), .rst_i(RST), .sw_ni(left_n), .pressed_o(lf_p)
  );
  switch_debounce #(.DEB_BITS(DEB_BITS)) u_deb_right (
    .clk_i(CLK), .rst_i(RST), .sw_ni(right_n), .pressed_o(rt_p)
  );

  pos_state_t          state_q, state_d;
  logic                frame_tick_q, frame_tick_d;
  logic [FcntW-1:0]    fcnt_q, fcnt_d;
  logic                strobe;
  coord_t              o_x_q, o_x_d, o_y_q, o_y_d;
  coord_t              nx_q, nx_d, ny_q, ny_d;
  coord_t              calc_x, calc_y;
  logic [3*RGB_W-1:0]  rgb_q, rgb_d;
  logic                dir_x, dir_y;
  logic                auto_en;

`ifdef VGA_SPRITE_BOUNCE_EN
  logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;

  assign auto_en = 1'b1;
  assign dir_x   = dir_x_q;
  assign dir_y   = dir_y_q;

  // Directions only steer the next calculation, so they can settle during CALC.
  always_comb begin
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (state_q == StCalc) begin
      dir_x_d = axis_dir($signed({1'b0, o_x_q}), dir_x_q, lf_p, rt_p, StepS, XMin, XMax);
      dir_y_d = axis_dir($signed({1'b0, o_y_q}), dir_y_q, up_p, dn_p, StepS, YMin, YMax);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end
`else
  assign auto_en = 1'b0;
  assign dir_x   = 1'b1;
  assign dir_y   = 1'b1;
`endif

  always_comb begin
    calc_x = axis_pos($signed({1'b0, o_x_q}), dir_x, lf_p, rt_p, auto_en, StepS, XMin, XMax);
    calc_y = axis_pos($signed({1'b0, o_y_q}), dir_y, up_p, dn_p, auto_en, StepS, YMin, YMax);
  end

  always_comb begin
    frame_tick_d = (x == '0) && (y == coord_t'(V_RES));
    strobe       = frame_tick_q && (fcnt_q == FcntLast);
    fcnt_d       = fcnt_q;
    if (frame_tick_q) fcnt_d = (fcnt_q == FcntLast) ? '0 : fcnt_q + 1'b1;

    state_d = state_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    o_x_d   = o_x_q;
    o_y_d   = o_y_q;
    unique case (state_q)
      StIdle: if (strobe) state_d = StCalc;
      StCalc: begin
        nx_d    = calc_x;
        ny_d    = calc_y;
        state_d = StCommit;
      end
      StCommit: begin
        o_x_d   = nx_q;
        o_y_d   = ny_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic    in_spr, in_brd;
  ucoord_t xu, yu, oxu, oyu;

  always_comb begin
    xu     = {1'b0, x};
    yu     = {1'b0, y};
    oxu    = {1'b0, o_x_q};
    oyu    = {1'b0, o_y_q};
    in_spr = (xu >= oxu) && (xu < oxu + SprWU) && (yu >= oyu) && (yu < oyu + SprHU);
    in_brd = (xu < BrdU) || (xu >= BrdRU) || (yu < BrdU) || (yu >= BrdBU);
    if (blank)       rgb_d = '0;
    else if (in_spr) rgb_d = SPR_RGB;
    else if (in_brd) rgb_d = BRD_RGB;
    else             rgb_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      frame_tick_q <= 1'b0;
      fcnt_q       <= '0;
      o_x_q        <= coord_t'(START_X);
      o_y_q        <= coord_t'(START_Y);
      nx_q         <= '0;
      ny_q         <= '0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      frame_tick_q <= frame_tick_d;
      fcnt_q       <= fcnt_d;
      o_x_q        <= o_x_d;
      o_y_q        <= o_y_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      rgb_q        <= rgb_d;
    end
  end

  assign {RED, GREEN, BLUE} = rgb_q;
  assign o_x                = o_x_q;
  assign o_y                = o_y_q;
  assign frame_tick         = frame_tick_q;

endmodule
